// File: rtl/doodle_jump_ctrl.sv
// Game-level sequencer for the doodle jump core: jump launch, fall tracking, landings, score and game over.
// Optional spring boost landing is compiled in with `define DOODLE_SPRING_EN.
module doodle_jump_ctrl #(
    parameter logic [7:0] JUMP_LEN   = 8'd40,
    parameter logic [7:0] BOOST_LEN  = 8'd80,
    parameter logic [7:0] FALL_LIMIT = 8'd60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic        tick,
    input  logic        plat_hit,
    input  logic        spring_hit,
    input  logic        core_q_I,
    input  logic        core_q_Up,
    input  logic        core_q_Down,
    input  logic        core_q_Done,
    output logic        core_start,
    output logic        core_ack,
    output logic [7:0]  core_jin,
    output logic [15:0] height,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic [7:0]  fall_depth,
    output logic        q_Idle,
    output logic        q_Arm,
    output logic        q_Rise,
    output logic        q_Fall,
    output logic        q_Land,
    output logic        q_Over
);

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_ARM  = 6'b000010,
        S_RISE = 6'b000100,
        S_FALL = 6'b001000,
        S_LAND = 6'b010000,
        S_OVER = 6'b100000
    } state_t;

    state_t      state_q, state_d;
    logic        core_start_q, core_start_d;
    logic        core_ack_q, core_ack_d;
    logic [7:0]  core_jin_q, core_jin_d;
    logic [15:0] height_q, height_d;
    logic [15:0] score_q, score_d;
    logic [15:0] hi_score_q, hi_score_d;
    logic [7:0]  fall_depth_q, fall_depth_d;
    logic        idle_seen_q, idle_seen_d;

    logic [8:0]         fd_inc;
    logic [7:0]         fd_sat;
    logic [8:0]         fall_limit;
    logic signed [9:0]  delta;
    logic signed [17:0] land_sum;
    logic [15:0]        land_height;
    logic [7:0]         jin_sel;
    logic               unused_ok;

    // core_jin holds its value outside ARM, so it is also the distance of the jump in flight.
    always_comb begin
        fd_inc      = {1'b0, fall_depth_q} + 9'd1;
        fd_sat      = fd_inc[8] ? 8'hFF : fd_inc[7:0];
        fall_limit  = {1'b0, core_jin_q} + {1'b0, FALL_LIMIT};
        delta       = $signed({2'b00, core_jin_q}) - $signed({2'b00, fd_sat});
        land_sum    = $signed({2'b00, height_q}) + {{8{delta[9]}}, delta};
        if (land_sum[17]) begin
            land_height = 16'h0000;
        end else if (land_sum[16]) begin
            land_height = 16'hFFFF;
        end else begin
            land_height = land_sum[15:0];
        end
    end

`ifdef DOODLE_SPRING_EN
    logic boost_q, boost_d;

    // Boost latch: set by a spring landing, consumed by the following ARM.
    always_comb begin
        boost_d = boost_q;
        if (state_q == S_IDLE && Start && core_q_I) begin
            boost_d = 1'b0;
        end else if (state_q == S_ARM && core_q_Up) begin
            boost_d = 1'b0;
        end else if (state_q == S_FALL && tick && plat_hit && spring_hit) begin
            boost_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            boost_q <= 1'b0;
        end else begin
            boost_q <= boost_d;
        end
    end

    assign jin_sel   = boost_d ? BOOST_LEN : JUMP_LEN;
    assign unused_ok = core_q_Done;
`else
    assign jin_sel   = JUMP_LEN;
    assign unused_ok = ^{spring_hit, core_q_Done, BOOST_LEN};
`endif

    // Handshake with the core: core_start is a level held for the whole of ARM and
    // dropped once the core reports Up; core_ack is a single-cycle pulse on entry to
    // LAND or OVER asking the core to park back in I. Start is only honoured in IDLE
    // with the core in I, and Ack only in OVER.
    always_comb begin
        state_d      = state_q;
        height_d     = height_q;
        score_d      = score_q;
        hi_score_d   = hi_score_q;
        fall_depth_d = fall_depth_q;
        idle_seen_d  = idle_seen_q;
        core_ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start && core_q_I) begin
                    state_d      = S_ARM;
                    height_d     = 16'd0;
                    score_d      = 16'd0;
                    fall_depth_d = 8'd0;
                end
            end
            S_ARM: begin
                if (core_q_Up) begin
                    state_d = S_RISE;
                end
            end
            S_RISE: begin
                if (core_q_Down) begin
                    state_d      = S_FALL;
                    fall_depth_d = 8'd0;
                end
            end
            S_FALL: begin
                if (tick) begin
                    fall_depth_d = fd_sat;
                    // A landing takes priority over running out of fall budget.
                    if (plat_hit) begin
                        state_d     = S_LAND;
                        height_d    = land_height;
                        score_d     = (land_height > score_q) ? land_height : score_q;
                        idle_seen_d = 1'b0;
                        core_ack_d  = 1'b1;
                    end else if (fd_inc >= fall_limit) begin
                        state_d    = S_OVER;
                        hi_score_d = (score_q > hi_score_q) ? score_q : hi_score_q;
                        core_ack_d = 1'b1;
                    end
                end
            end
            S_LAND: begin
                if (core_q_I) begin
                    idle_seen_d = 1'b1;
                end
                if (tick && (idle_seen_q || core_q_I)) begin
                    state_d     = S_ARM;
                    idle_seen_d = 1'b0;
                end
            end
            S_OVER: begin
                if (Ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        core_start_d = (state_d == S_ARM);
        core_jin_d   = (state_d == S_ARM) ? jin_sel : core_jin_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            core_start_q <= 1'b0;
            core_ack_q   <= 1'b0;
            core_jin_q   <= JUMP_LEN;
            height_q     <= 16'd0;
            score_q      <= 16'd0;
            hi_score_q   <= 16'd0;
            fall_depth_q <= 8'd0;
            idle_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            core_ack_q   <= core_ack_d;
            core_jin_q   <= core_jin_d;
            height_q     <= height_d;
            score_q      <= score_d;
            hi_score_q   <= hi_score_d;
            fall_depth_q <= fall_depth_d;
            idle_seen_q  <= idle_seen_d;
        end
    end

    assign core_start = core_start_q;
    assign core_ack   = core_ack_q;
    assign core_jin   = core_jin_q;
    assign height     = height_q;
    assign score      = score_q;
    assign hi_score   = hi_score_q;
    assign fall_depth = fall_depth_q;
    assign q_Idle     = state_q[0];
    assign q_Arm      = state_q[1];
    assign q_Rise     = state_q[2];
    assign q_Fall     = state_q[3];
    assign q_Land     = state_q[4];
    assign q_Over     = state_q[5];

endmodule
